// File: rtl/register_file_16x_pkg.sv
// register_file_16x_pkg: shared sizes and the word type for the 16-entry register file.
package register_file_16x_pkg;
  localparam int REG_COUNT = 16;
  localparam int ADDR_W = 4;
  localparam int WORD_W = 16;
  localparam logic [ADDR_W-1:0] PC_IDX = 4'd15;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/register_file_16x_decoder.sv
// decoder_4to16: one-hot register load enables from the write strobe and address; R15 never loads.
module decoder_4to16
  import register_file_16x_pkg::*;
(
  input  logic                 i_write_en,
  input  logic [ADDR_W-1:0]    i_write_addr,
  output logic [REG_COUNT-1:0] o_load_en
);
  logic [REG_COUNT-1:0] w_dec;
  assign w_dec = i_write_en ? REG_COUNT'(1) << i_write_addr : '0;
  assign o_load_en = w_dec & {1'b0, {(REG_COUNT-1){1'b1}}};
endmodule

// File: rtl/register_file_16x_mux.sv
// mux_16to1: W-bit 16-input select over a flat bus, input 0 in the low bits.
module mux_16to1
  import register_file_16x_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [ADDR_W-1:0]      i_sel,
  input  logic [REG_COUNT*W-1:0] i_data,
  output logic [W-1:0]           o_data
);
  assign o_data = i_data[i_sel*W +: W];
endmodule

// File: rtl/register_file_16x.sv
// register_file_16x: 15 stored registers plus R15 = pc_in, two combinational read ports, one write port.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data to matching read ports.
module register_file_16x
  import register_file_16x_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_en,
  input  logic [ADDR_W-1:0]    write_addr,
  input  logic [W-1:0]         write_data,
  input  logic [ADDR_W-1:0]    read_addr1,
  input  logic [ADDR_W-1:0]    read_addr2,
  input  logic [W-1:0]         pc_in,
  output logic [W-1:0]         read_data1,
  output logic [W-1:0]         read_data2,
  output logic [REG_COUNT*W-1:0] dbg_reg_out
);
  logic [W-1:0]           r_regs [REG_COUNT-1];
  logic [REG_COUNT-1:0]   w_load;
  logic [REG_COUNT*W-1:0] w_flat;
  logic [W-1:0]           w_mux1;
  logic [W-1:0]           w_mux2;

  decoder_4to16 u_dec (
    .i_write_en  (write_en),
    .i_write_addr(write_addr),
    .o_load_en   (w_load)
  );

  always_ff @(posedge clk) begin
    for (int i = 0; i < REG_COUNT - 1; i++)
      if (reset) r_regs[i] <= '0;
      else if (w_load[i]) r_regs[i] <= write_data;
  end

  for (genvar g = 0; g < REG_COUNT - 1; g++) begin : g_flat
    assign w_flat[g*W +: W] = r_regs[g];
  end
  assign w_flat[(REG_COUNT-1)*W +: W] = pc_in;
  assign dbg_reg_out = w_flat;

  mux_16to1 #(.W(W)) u_mux1 (.i_sel(read_addr1), .i_data(w_flat), .o_data(w_mux1));
  mux_16to1 #(.W(W)) u_mux2 (.i_sel(read_addr2), .i_data(w_flat), .o_data(w_mux2));

`ifdef REGFILE_WRITE_BYPASS_EN
  // w_load[15] is always 0, so the pc slot is never forwarded
  assign read_data1 = (w_load[read_addr1] && !reset) ? write_data : w_mux1;
  assign read_data2 = (w_load[read_addr2] && !reset) ? write_data : w_mux2;
`else
  logic w_unused_pc_load;
  assign w_unused_pc_load = w_load[PC_IDX];
  assign read_data1 = w_mux1;
  assign read_data2 = w_mux2;
`endif
endmodule

// File: tb/tb_register_file_16x.sv
// tb_register_file_16x: directed checks of reset, writes, R15/pc_in, dual read and read-during-write.
module tb_register_file_16x;
  import register_file_16x_pkg::*;
  logic clk = 0;
  logic reset = 1;
  logic write_en = 0;
  logic [3:0] write_addr = 0;
  word_t write_data = 0;
  logic [3:0] read_addr1 = 0;
  logic [3:0] read_addr2 = 0;
  word_t pc_in = 0;
  word_t read_data1, read_data2;
  logic [255:0] dbg_reg_out;
  word_t m [15];
  int n_chk = 0;
  int n_fail = 0;

  register_file_16x #(.W(16)) dut (
    .clk(clk), .reset(reset), .write_en(write_en), .write_addr(write_addr),
    .write_data(write_data), .read_addr1(read_addr1), .read_addr2(read_addr2),
    .pc_in(pc_in), .read_data1(read_data1), .read_data2(read_data2),
    .dbg_reg_out(dbg_reg_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_dbg(input string tag);
    logic [255:0] exp;
    exp = {pc_in, 240'd0};
    for (int i = 0; i < 15; i++) exp[i*16 +: 16] = m[i];
    n_chk++;
    assert (dbg_reg_out === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, dbg_reg_out, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input word_t d);
    write_en = 1;
    write_addr = a;
    write_data = d;
    tick();
    write_en = 0;
    if (a != 4'd15) m[a] = d;
  endtask

  initial begin
    for (int i = 0; i < 15; i++) m[i] = '0;
    tick();
    tick();
    reset = 0;
    chk_dbg("reset_dbg");
    wr(4'd3, 16'h1234);
    read_addr1 = 3;
    #1 chk("preload_r3", read_data1, 16'h1234);
    reset = 1;
    write_en = 1;
    write_addr = 5;
    write_data = 16'hFFFF;
    tick();
    reset = 0;
    write_en = 0;
    m[3] = '0;
    for (int i = 0; i < 15; i++) begin
      read_addr1 = 4'(i);
      #1 chk($sformatf("reset_r%0d", i), read_data1, 16'h0000);
    end
    chk_dbg("reset_wr_dbg");
    reset = 1;
    write_en = 1;
    write_addr = 6;
    write_data = 16'h5555;
    tick();
    tick();
    reset = 0;
    write_en = 0;
    chk_dbg("reset_held_dbg");
    wr(4'd7, 16'hBEEF);
    read_addr1 = 7;
    read_addr2 = 7;
    #1 chk("r7_port1", read_data1, 16'hBEEF);
    chk("r7_port2", read_data2, 16'hBEEF);
    chk_dbg("r7_dbg");
    pc_in = 16'h0040;
    wr(4'd15, 16'hAAAA);
    read_addr1 = 15;
    #1 chk("r15_pc40", read_data1, 16'h0040);
    chk_dbg("r15_nowrite_dbg");
    pc_in = 16'h0044;
    #1 chk("r15_pc44", read_data1, 16'h0044);
    wr(4'd1, 16'h0001);
    wr(4'd14, 16'h8000);
    read_addr1 = 1;
    read_addr2 = 14;
    #1 chk("dual_r1", read_data1, 16'h0001);
    chk("dual_r14", read_data2, 16'h8000);
    wr(4'd2, 16'h1111);
    write_en = 1;
    write_addr = 2;
    write_data = 16'h2222;
    read_addr1 = 2;
    read_addr2 = 3;
`ifdef REGFILE_WRITE_BYPASS_EN
    #1 chk("rdw_same_cycle", read_data1, 16'h2222);
`else
    #1 chk("rdw_same_cycle", read_data1, 16'h1111);
`endif
    chk("rdw_other_port", read_data2, 16'h0000);
    tick();
    write_en = 0;
    m[2] = 16'h2222;
    chk("rdw_next_cycle", read_data1, 16'h2222);
    wr(4'd0, 16'h0001);
    wr(4'd0, 16'h0002);
    wr(4'd0, 16'h0003);
    write_data = 16'hDEAD;
    write_addr = 0;
    tick();
    read_addr1 = 0;
    #1 chk("b2b_r0", read_data1, 16'h0003);
    chk_dbg("final_dbg");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
